// File: rtl/div_seq.sv
// DIV AB sequencer: latches operands, enables the divider for DIV_CYCLES clocks and pulses done
// once (done DIV_CYCLES+1 cycles after accept, 1 cycle for divide-by-zero). start is dropped while busy.
module div_seq #(
   parameter int DIV_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   output logic       ready_o,
   input  logic [7:0] src_a_i,
   input  logic [7:0] src_b_i,
   output logic       done_o,
   output logic [7:0] quot_o,
   output logic [7:0] rem_o,
   output logic       ov_o,
   output logic       cy_o,
   output logic       div_enable_o,
   output logic [7:0] div_src1_o,
   output logic [7:0] div_src2_o,
   input  logic [7:0] div_rem_i,
   input  logic [7:0] div_quot_i,
   input  logic       div_ov_i
);

   localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       op_a_q, op_a_d;
   logic [7:0]       op_b_q, op_b_d;
   logic [7:0]       quot_q, quot_d;
   logic [7:0]       rem_q, rem_d;
   logic             ov_q, ov_d;
   logic             cy_q, cy_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         ov_q    <= 1'b0;
         cy_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         ov_q    <= ov_d;
         cy_q    <= cy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      ov_d    = ov_q;
      cy_d    = cy_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               op_a_d = src_a_i;
               op_b_d = src_b_i;
               cnt_d  = '0;
               if (src_b_i != 8'd0) begin
                  state_d = RUN;
               end else begin
                  // Divide-by-zero bypasses the divider so its counter stays at 0.
                  state_d = DONE;
                  quot_d  = src_a_i;
                  rem_d   = src_b_i;
                  ov_d    = 1'b1;
                  cy_d    = 1'b0;
               end
            end
         end
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               quot_d  = div_quot_i;
               rem_d   = div_rem_i;
               ov_d    = 1'b0;
               cy_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ready_o      = (state_q == IDLE);
   assign done_o       = (state_q == DONE);
   assign div_enable_o = (state_q == RUN);
   assign div_src1_o   = op_a_q;
   assign div_src2_o   = op_b_q;
   assign quot_o       = quot_q;
   assign rem_o        = rem_q;
   assign ov_o         = ov_q;
   assign cy_o         = cy_q;

   // The divisor register is never zero while RUN, so the divider cannot flag overflow.
   a_no_ov_while_enabled : assert property (
      @(posedge clk_i) disable iff (!rst_ni) div_enable_o |-> !div_ov_i);

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: behavioural divider stub, per-cycle reference model and directed/random stimulus.
module tb_div_seq;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic       ready_o;
   logic [7:0] src_a_i, src_b_i;
   logic       done_o;
   logic [7:0] quot_o, rem_o;
   logic       ov_o, cy_o;
   logic       div_enable_o;
   logic [7:0] div_src1_o, div_src2_o;
   logic [7:0] div_rem_i, div_quot_i;
   logic       div_ov_i;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   div_seq #(.DIV_CYCLES(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ready_o(ready_o),
      .src_a_i(src_a_i), .src_b_i(src_b_i), .done_o(done_o), .quot_o(quot_o),
      .rem_o(rem_o), .ov_o(ov_o), .cy_o(cy_o), .div_enable_o(div_enable_o),
      .div_src1_o(div_src1_o), .div_src2_o(div_src2_o), .div_rem_i(div_rem_i),
      .div_quot_i(div_quot_i), .div_ov_i(div_ov_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Divider stub: 2-bit cycle counter, src1 taken in cycle 0, result valid only in cycle 3.
   logic [1:0] dcnt;
   logic [7:0] dlat;
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dcnt <= 2'd0;
         dlat <= 8'd0;
      end else if (div_enable_o) begin
         if (dcnt == 2'd0) dlat <= div_src1_o;
         dcnt <= dcnt + 2'd1;
      end
   end
   always_comb begin
      div_quot_i = 8'hA5 ^ {6'd0, dcnt};
      div_rem_i  = 8'h5A;
      div_ov_i   = (div_src2_o == 8'd0);
      if (dcnt == 2'd3 && div_src2_o != 8'd0) begin
         div_quot_i = dlat / div_src2_o;
         div_rem_i  = dlat % div_src2_o;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: timing windows and results computed from the operands at accept.
   int         m_free, m_done, m_run_lo, m_run_hi;
   logic [7:0] m_a, m_b, m_pq, m_pr, m_lq, m_lr;
   logic       m_pov, m_lov;
   bit         e_ready, e_done, e_en;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         m_free = 0; m_done = -1; m_run_lo = -1; m_run_hi = -2;
         m_a = 0; m_b = 0; m_lq = 0; m_lr = 0; m_lov = 0;
         chk("rst_ready", ready_o, 1);
         chk("rst_done", done_o, 0);
         chk("rst_enable", div_enable_o, 0);
         chk("rst_quot", quot_o, 0);
         chk("rst_rem", rem_o, 0);
         chk("rst_ov", ov_o, 0);
         chk("rst_cy", cy_o, 0);
         chk("rst_src1", div_src1_o, 0);
         chk("rst_src2", div_src2_o, 0);
      end else begin
         e_ready = (cyc >= m_free);
         e_done  = (cyc == m_done);
         e_en    = (cyc >= m_run_lo && cyc <= m_run_hi);
         if (e_done) begin
            m_lq = m_pq; m_lr = m_pr; m_lov = m_pov;
         end
         chk("ready", ready_o, e_ready);
         chk("done", done_o, e_done);
         chk("enable", div_enable_o, e_en);
         chk("quot", quot_o, m_lq);
         chk("rem", rem_o, m_lr);
         chk("ov", ov_o, m_lov);
         chk("cy", cy_o, 0);
         chk("src1", div_src1_o, m_a);
         chk("src2", div_src2_o, m_b);
         if (e_ready && start_i === 1'b1) begin
            m_a = src_a_i;
            m_b = src_b_i;
            if (m_b == 0) begin
               m_pq = m_a; m_pr = 0; m_pov = 1;
               m_done = cyc + 1;
            end else begin
               m_pq = m_a / m_b; m_pr = m_a % m_b; m_pov = 0;
               m_run_lo = cyc + 1; m_run_hi = cyc + 4;
               m_done = cyc + 5;
            end
            m_free = m_done + 1;
         end
      end
   end

   task automatic pulse_start(input logic [7:0] a, input logic [7:0] b, output int t0);
      @(posedge clk_i); #1;
      start_i = 1'b1; src_a_i = a; src_b_i = b; t0 = cyc;
      @(posedge clk_i); #1;
      start_i = 1'b0; src_a_i = 8'($urandom); src_b_i = 8'($urandom);
   endtask

   task automatic wait_done(input int t0, input logic [7:0] eq, input logic [7:0] er,
                            input logic eov, input int elat, input string nm);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_i);
         if (done_o) seen = 1;
      end
      chk({nm, "_done_seen"}, seen, 1);
      if (seen) begin
         chk({nm, "_latency"}, cyc - t0, elat);
         chk({nm, "_quot"}, quot_o, eq);
         chk({nm, "_rem"}, rem_o, er);
         chk({nm, "_ov"}, ov_o, eov);
         chk({nm, "_cy"}, cy_o, 0);
      end
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic eov, input int elat, input string nm);
      int t0;
      pulse_start(a, b, t0);
      wait_done(t0, eq, er, eov, elat, nm);
   endtask

   initial begin
      int t0;
      rst_ni = 1'b1; start_i = 1'b0; src_a_i = 8'd0; src_b_i = 8'd0;
      #2 rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      do_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 5, "t1_200_7");
      do_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 5, "t2_255_1");
      do_op(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 5, "t2_3_10");
      do_op(8'd5, 8'd0, 8'd5, 8'd0, 1'b1, 1, "t3_5_0");
      do_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 5, "t3_9_3");

      // Start pulsed again in RUN cycle 2 must be ignored.
      pulse_start(8'd200, 8'd7, t0);
      #0;
      @(posedge clk_i); #1;
      start_i = 1'b1; src_a_i = 8'd1; src_b_i = 8'd1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      wait_done(t0, 8'd28, 8'd4, 1'b0, 5, "t4_ignore");
      repeat (8) @(posedge clk_i);
      #1;
      chk("t4_single_done", done_o, 0);

      // Reset in RUN cycle 2 of 100/9 aborts without a done pulse.
      pulse_start(8'd100, 8'd9, t0);
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      @(negedge clk_i);
      chk("t5_rst_quot", quot_o, 0);
      chk("t5_rst_done", done_o, 0);
      chk("t5_rst_enable", div_enable_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      do_op(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 5, "t5_100_9");

      // Random traffic: frequent starts (many while busy), occasional zero divisors.
      for (int i = 0; i < 15000; i++) begin
         @(posedge clk_i); #1;
         start_i = ($urandom_range(0, 3) != 0);
         src_a_i = 8'($urandom);
         src_b_i = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom);
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
